// File: rtl/iiitb_tlc_sensor_cond.sv
// Vehicle-detector conditioning for the traffic light controller: synchronises,
// debounces and hold-stretches the farm-road loop detector, counts arrivals, flags a stuck loop.
module iiitb_tlc_sensor_cond #(
    parameter int DEBOUNCE_CYC = 8,
    parameter int HOLD_CYC     = 16,
    parameter int STUCK_CYC    = 4096,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             det_raw,
    input  logic             fault_clr,
    input  logic             cnt_clr,
    output logic             sensor,
    output logic             veh_pulse,
    output logic [CNT_W-1:0] veh_count,
    output logic             stuck_fault
);

    localparam int CW = $clog2(STUCK_CYC + 1);
    localparam logic [CW-1:0] DB_LIM    = CW'(DEBOUNCE_CYC);
    localparam logic [CW-1:0] HOLD_LIM  = CW'(HOLD_CYC);
    localparam logic [CW-1:0] STUCK_LIM = CW'(STUCK_CYC);
    localparam logic [CW-1:0] ONE       = CW'(1);

    typedef enum logic [2:0] {
        ABSENT   = 3'd0,
        QUAL_ON  = 3'd1,
        PRESENT  = 3'd2,
        QUAL_OFF = 3'd3,
        FAULT    = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic             sync1_reg, sync2_reg;
    logic [CW-1:0]    db_cnt_reg, db_cnt_next;
    logic [CW-1:0]    hold_cnt_reg, hold_cnt_next;
    logic [CW-1:0]    stuck_cnt_reg, stuck_cnt_next;
    logic             sensor_reg, sensor_next;
    logic             pulse_reg, pulse_next;
    logic             fault_reg, fault_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CW-1:0]    db_inc, hold_inc;
    logic             arrive;
    logic             det_s;

    assign det_s = sync2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg     <= 1'b0;
            sync2_reg     <= 1'b0;
            state_reg     <= ABSENT;
            db_cnt_reg    <= '0;
            hold_cnt_reg  <= '0;
            stuck_cnt_reg <= '0;
            sensor_reg    <= 1'b0;
            pulse_reg     <= 1'b0;
            fault_reg     <= 1'b0;
            count_reg     <= '0;
        end else begin
            sync1_reg     <= det_raw;
            sync2_reg     <= sync1_reg;
            state_reg     <= state_next;
            db_cnt_reg    <= db_cnt_next;
            hold_cnt_reg  <= hold_cnt_next;
            stuck_cnt_reg <= stuck_cnt_next;
            sensor_reg    <= sensor_next;
            pulse_reg     <= pulse_next;
            fault_reg     <= fault_next;
            count_reg     <= count_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        db_cnt_next    = db_cnt_reg;
        hold_cnt_next  = hold_cnt_reg;
        stuck_cnt_next = stuck_cnt_reg;
        pulse_next     = 1'b0;
        count_next     = cnt_clr ? '0 : count_reg;
        arrive         = 1'b0;
        db_inc         = db_cnt_reg + 1'b1;
        hold_inc       = (hold_cnt_reg >= HOLD_LIM) ? HOLD_LIM : hold_cnt_reg + 1'b1;

        case (state_reg)
            ABSENT: begin
                if (det_s) begin
                    if (ONE >= DB_LIM) begin
                        arrive = 1'b1;
                    end else begin
                        state_next  = QUAL_ON;
                        db_cnt_next = ONE;
                    end
                end
            end
            QUAL_ON: begin
                if (!det_s) begin
                    state_next  = ABSENT;
                    db_cnt_next = '0;
                end else if (db_inc >= DB_LIM) begin
                    arrive = 1'b1;
                end else begin
                    db_cnt_next = db_inc;
                end
            end
            PRESENT: begin
                hold_cnt_next = hold_inc;
                if (det_s) begin
                    // Counter already holds the full run length here, so the fault lands one edge later.
                    if (stuck_cnt_reg >= STUCK_LIM) begin
                        state_next = FAULT;
                    end else begin
                        stuck_cnt_next = stuck_cnt_reg + 1'b1;
                    end
                end else begin
                    state_next     = QUAL_OFF;
                    db_cnt_next    = ONE;
                    stuck_cnt_next = '0;
                end
            end
            QUAL_OFF: begin
                hold_cnt_next = hold_inc;
                if (det_s) begin
                    state_next     = PRESENT;
                    db_cnt_next    = '0;
                    stuck_cnt_next = ONE;
                end else if (db_inc >= DB_LIM && hold_cnt_reg >= HOLD_LIM) begin
                    state_next    = ABSENT;
                    db_cnt_next   = '0;
                    hold_cnt_next = '0;
                end else begin
                    db_cnt_next = (db_inc >= DB_LIM) ? DB_LIM : db_inc;
                end
            end
            FAULT: begin
                if (fault_clr && !det_s) begin
                    state_next     = ABSENT;
                    db_cnt_next    = '0;
                    hold_cnt_next  = '0;
                    stuck_cnt_next = '0;
                end
            end
            default: begin
                state_next = ABSENT;
            end
        endcase

        // A qualified arrival wins over a coincident counter clear.
        if (arrive) begin
            state_next     = PRESENT;
            db_cnt_next    = '0;
            hold_cnt_next  = ONE;
            stuck_cnt_next = ONE;
            pulse_next     = 1'b1;
            if (cnt_clr) begin
                count_next = CNT_W'(1);
            end else if (count_reg != '1) begin
                count_next = count_reg + 1'b1;
            end
        end

        sensor_next = (state_next == PRESENT) || (state_next == QUAL_OFF) ||
                      (state_next == FAULT);
        fault_next  = (state_next == FAULT);
    end

    assign sensor      = sensor_reg;
    assign veh_pulse   = pulse_reg;
    assign veh_count   = count_reg;
    assign stuck_fault = fault_reg;

endmodule

// File: tb/tb_iiitb_tlc_sensor_cond.sv
// Event-scoreboard bench for iiitb_tlc_sensor_cond: stimulus queues expected output
// changes (edge number + output tuple), a monitor pops one per observed change.
module tb_iiitb_tlc_sensor_cond;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          det_raw = 1'b0;
    logic          fault_clr = 1'b0;
    logic          cnt_clr = 1'b0;
    logic          sensor, veh_pulse, stuck_fault;
    logic [CW-1:0] veh_count;

    iiitb_tlc_sensor_cond #(
        .DEBOUNCE_CYC(4),
        .HOLD_CYC    (16),
        .STUCK_CYC   (64),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .det_raw    (det_raw),
        .fault_clr  (fault_clr),
        .cnt_clr    (cnt_clr),
        .sensor     (sensor),
        .veh_pulse  (veh_pulse),
        .veh_count  (veh_count),
        .stuck_fault(stuck_fault)
    );

    always #5 clk = ~clk;

    // outs = {sensor, veh_pulse, veh_count[1:0], stuck_fault}
    typedef struct {
        int         edge_n;
        logic [4:0] outs;
    } ev_t;

    ev_t           exp_q[$];
    int            tests = 0;
    int            fails = 0;
    int            edge_cnt = 0;
    logic [CW-1:0] exp_count = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    function automatic logic [4:0] outs();
        return {sensor, veh_pulse, veh_count, stuck_fault};
    endfunction

    function automatic void push(input int e, input logic [4:0] o);
        ev_t ev;
        ev.edge_n = e;
        ev.outs   = o;
        exp_q.push_back(ev);
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got outs=%b, expected %b", name, act, exp);
        end else begin
            $display("[TB] %s outs=%b ok", name, act);
        end
    endtask

    // Raise det_raw for len edges; qualified runs queue rise, pulse-end and fall events.
    task automatic arrival(input int len, input bit clr_at_rise);
        int k;
        int f;
        k = edge_cnt;
        det_raw = 1'b1;
        if (len >= 4) begin
            if (clr_at_rise)            exp_count = 2'd1;
            else if (exp_count != 2'd3) exp_count = exp_count + 2'd1;
            push(k + 6, {1'b1, 1'b1, exp_count, 1'b0});
            push(k + 7, {1'b1, 1'b0, exp_count, 1'b0});
            f = (k + len + 6 > k + 22) ? k + len + 6 : k + 22;
            push(f, {1'b0, 1'b0, exp_count, 1'b0});
        end
        for (int i = 1; i <= len; i++) begin
            step(1);
            if (clr_at_rise) cnt_clr = (i == 5);
        end
        cnt_clr = 1'b0;
        det_raw = 1'b0;
    endtask

    initial begin : monitor
        logic [4:0] prev;
        logic [4:0] cur;
        ev_t        e;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = outs();
            if (!rst_n) begin
                prev = '0;
            end else if (cur !== prev) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL unexpected_change at edge %0d: got outs=%b, expected unchanged %b",
                             edge_cnt, cur, prev);
                end else begin
                    e = exp_q.pop_front();
                    if (e.edge_n != edge_cnt || e.outs !== cur) begin
                        fails++;
                        $display("[TB] FAIL event: got edge %0d outs=%b, expected edge %0d outs=%b",
                                 edge_cnt, cur, e.edge_n, e.outs);
                    end else begin
                        $display("[TB] edge %0d sensor=%b pulse=%b count=%0d fault=%b ok",
                                 edge_cnt, cur[4], cur[3], cur[2:1], cur[0]);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin : stimulus
        #12;
        check("reset_state", outs(), 5'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean arrival: first high sample at edge 10, rise at 15, fall at 45.
        step(9);
        arrival(30, 1'b0);
        step(30);

        // Glitches of 1, 2 and 3 cycles: no events expected.
        arrival(1, 1'b0); step(10);
        arrival(2, 1'b0); step(10);
        arrival(3, 1'b0); step(10);

        // Short presence stretched to the 16-cycle hold minimum.
        arrival(5, 1'b0);
        step(30);

        // Two-cycle dropout mid-presence: one arrival, one fall.
        begin
            int k;
            k = edge_cnt;
            exp_count = (exp_count == 2'd3) ? 2'd3 : exp_count + 2'd1;
            push(k + 6,  {1'b1, 1'b1, exp_count, 1'b0});
            push(k + 7,  {1'b1, 1'b0, exp_count, 1'b0});
            push(k + 48, {1'b0, 1'b0, exp_count, 1'b0});
            det_raw = 1'b1; step(20);
            det_raw = 1'b0; step(2);
            det_raw = 1'b1; step(20);
            det_raw = 1'b0; step(10);
        end

        // Stuck detector: fault 70 edges after det_raw rises; clear only once det_s is low.
        begin
            int k;
            k = edge_cnt;
            exp_count = (exp_count == 2'd3) ? 2'd3 : exp_count + 2'd1;
            push(k + 6,  {1'b1, 1'b1, exp_count, 1'b0});
            push(k + 7,  {1'b1, 1'b0, exp_count, 1'b0});
            push(k + 70, {1'b1, 1'b0, exp_count, 1'b1});
            det_raw = 1'b1;
            step(75);
            fault_clr = 1'b1; step(1); fault_clr = 1'b0;
            step(3);
            det_raw = 1'b0;
            step(3);
            push(edge_cnt + 1, {1'b0, 1'b0, exp_count, 1'b0});
            fault_clr = 1'b1; step(1); fault_clr = 1'b0;
            step(10);
        end

        // Counter clear from saturation, five arrivals, clear coincident with arrival, clear alone.
        exp_count = '0;
        push(edge_cnt + 1, 5'b0);
        cnt_clr = 1'b1; step(1); cnt_clr = 1'b0;
        step(3);
        for (int n = 0; n < 5; n++) begin
            arrival(8, 1'b0);
            step(20);
        end
        arrival(8, 1'b1);
        step(20);
        exp_count = '0;
        push(edge_cnt + 1, 5'b0);
        cnt_clr = 1'b1; step(1); cnt_clr = 1'b0;
        step(5);

        // Asynchronous reset while PRESENT, then re-qualification with det_raw held high.
        begin
            int k;
            k = edge_cnt;
            exp_count = 2'd1;
            push(k + 6, {1'b1, 1'b1, exp_count, 1'b0});
            push(k + 7, {1'b1, 1'b0, exp_count, 1'b0});
            det_raw = 1'b1;
            step(10);
            check("pre_reset_present", outs(), {1'b1, 1'b0, exp_count, 1'b0});
            @(posedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            check("async_reset", outs(), 5'b0);
            exp_count = '0;
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            arrival(20, 1'b0);
            step(30);
        end

        step(5);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL pending_events: got %0d unseen, expected 0 (next edge %0d outs=%b)",
                     exp_q.size(), exp_q[0].edge_n, exp_q[0].outs);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
